// File: rtl/slice_decode_scheduler_pkg.sv
// Shared states, constants and helpers for the picture-level slice scheduler.
package slice_decode_scheduler_pkg;

  typedef enum logic [2:0] {
    SLICE_SCHED_IDLE      = 3'd0,
    SLICE_SCHED_WAIT_CODE = 3'd1,
    SLICE_SCHED_LAUNCH    = 3'd2,
    SLICE_SCHED_RUN       = 3'd3,
    SLICE_SCHED_END_MARK  = 3'd4
  } sched_state_e;

  // Info tag for the picture-end word; kept apart from the slice-quant tag.
  localparam logic [15:0] INFO_PICTURE_END = 16'hFE01;
  localparam logic [7:0]  SLICE_CODE_MIN   = 8'h01;
  localparam logic [7:0]  SLICE_CODE_MAX   = 8'hAF;

  function automatic logic is_slice_code(input logic [7:0] code);
    return (code >= SLICE_CODE_MIN) && (code <= SLICE_CODE_MAX);
  endfunction

  function automatic logic [31:0] picture_end_marker(input logic [7:0] count);
    return {INFO_PICTURE_END, 8'h00, count};
  endfunction

endpackage

// File: rtl/slice_decode_scheduler_watchdog.sv
// 12-bit start-code watchdog: counts enabled cycles, flags when the limit is reached.
module slice_sched_watchdog #(
  parameter logic [11:0] LIMIT = 12'd4095
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  logic [11:0] r_count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 12'd1;
    end
  end

  assign o_expire = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/slice_decode_scheduler.sv
// Picture-level slice launcher and slice-buffer mux in front of Slice_Decode.
// Optional row-order checking is built when SLICE_SCHED_ORDER_CHECK_EN is defined.
module slice_decode_scheduler
  import slice_decode_scheduler_pkg::*;
#(
  parameter logic [7:0]  MAX_SLICE_ROW  = 8'h24,
  parameter logic [11:0] TIMEOUT_CYCLES = 12'd4095
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        Start_Picture_I,
  output logic        Done_Picture_O,
  input  logic        Start_Code_Upcoming_I,
  input  logic [7:0]  Start_Code_Value_I,
  output logic        Start_Slice_Decode_O,
  input  logic        Done_Slice_Decode_I,
  input  logic [31:0] Slice_Value_I,
  input  logic        Slice_Write_En_I,
  output logic [31:0] Buffer_Value_O,
  output logic        Buffer_Write_En_O,
  input  logic        Buffer_Full_I,
  output logic [7:0]  Slice_Vertical_Position_O,
  output logic [7:0]  Slice_Count_O,
  output logic        Error_O
);

`ifdef SLICE_SCHED_ORDER_CHECK_EN
  localparam bit ORDER_CHECK = 1'b1;
`else
  localparam bit ORDER_CHECK = 1'b0;
`endif

  sched_state_e r_state, w_next;
  logic [7:0]   r_slice_count, r_row;
  logic         r_error, r_run_first;
  logic         w_expire, w_is_slice, w_order_err, w_take_slice, w_set_err, w_end_mark;

  slice_sched_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clock    (clock),
    .resetn   (resetn),
    .i_clear  (r_state != SLICE_SCHED_WAIT_CODE),
    .i_enable (r_state == SLICE_SCHED_WAIT_CODE),
    .o_expire (w_expire)
  );

  assign w_is_slice  = is_slice_code(Start_Code_Value_I);
  assign w_order_err = ORDER_CHECK && ((Start_Code_Value_I > MAX_SLICE_ROW) ||
                       ((r_slice_count != 8'h00) && (Start_Code_Value_I < r_row)));

  always_comb begin
    w_next       = r_state;
    w_take_slice = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      SLICE_SCHED_IDLE:
        if (Start_Picture_I) w_next = SLICE_SCHED_WAIT_CODE;
      SLICE_SCHED_WAIT_CODE:
        if (Start_Code_Upcoming_I && w_is_slice && Done_Slice_Decode_I) begin
          w_take_slice = 1'b1;
          w_set_err    = w_order_err;
          w_next       = SLICE_SCHED_LAUNCH;
        end else if (Start_Code_Upcoming_I && !w_is_slice) begin
          w_next = SLICE_SCHED_END_MARK;
        end else if (w_expire) begin
          w_set_err = 1'b1;
          w_next    = SLICE_SCHED_END_MARK;
        end
      SLICE_SCHED_LAUNCH:
        w_next = SLICE_SCHED_RUN;
      SLICE_SCHED_RUN:
        // Still idle right after the launch pulse means Slice_Decode never started.
        if (Done_Slice_Decode_I) begin
          if (r_run_first) begin
            w_set_err = 1'b1;
            w_next    = SLICE_SCHED_END_MARK;
          end else begin
            w_next = SLICE_SCHED_WAIT_CODE;
          end
        end
      SLICE_SCHED_END_MARK:
        if (!Buffer_Full_I) w_next = SLICE_SCHED_IDLE;
      default:
        w_next = SLICE_SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= SLICE_SCHED_IDLE;
      r_slice_count <= 8'h00;
      r_row         <= 8'h00;
      r_error       <= 1'b0;
      r_run_first   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_run_first <= (r_state == SLICE_SCHED_LAUNCH);
      if ((r_state == SLICE_SCHED_IDLE) && Start_Picture_I) begin
        r_slice_count <= 8'h00;
        r_error       <= 1'b0;
      end else begin
        if (w_set_err) r_error <= 1'b1;
        if ((r_state == SLICE_SCHED_LAUNCH) && (r_slice_count != 8'hFF))
          r_slice_count <= r_slice_count + 8'd1;
      end
      if (w_take_slice) r_row <= Start_Code_Value_I;
    end
  end

  assign w_end_mark                = (r_state == SLICE_SCHED_END_MARK);
  assign Done_Picture_O            = (r_state == SLICE_SCHED_IDLE);
  assign Start_Slice_Decode_O      = (r_state == SLICE_SCHED_LAUNCH);
  assign Buffer_Value_O            = w_end_mark ? picture_end_marker(r_slice_count) : Slice_Value_I;
  assign Buffer_Write_En_O         = (w_end_mark && !Buffer_Full_I) || Slice_Write_En_I;
  assign Slice_Vertical_Position_O = r_row;
  assign Slice_Count_O             = r_slice_count;
  assign Error_O                   = r_error;

endmodule

// File: tb/tb_slice_decode_scheduler.sv
// Randomized self-checking bench for slice_decode_scheduler against a cycle-level picture model.
module tb_slice_decode_scheduler;

  logic        clock = 1'b0;
  logic        resetn;
  logic        Start_Picture_I, Done_Picture_O;
  logic        Start_Code_Upcoming_I;
  logic [7:0]  Start_Code_Value_I;
  logic        Start_Slice_Decode_O, Done_Slice_Decode_I;
  logic [31:0] Slice_Value_I, Buffer_Value_O;
  logic        Slice_Write_En_I, Buffer_Write_En_O, Buffer_Full_I;
  logic [7:0]  Slice_Vertical_Position_O, Slice_Count_O;
  logic        Error_O;

  slice_decode_scheduler dut (
    .clock                     (clock),
    .resetn                    (resetn),
    .Start_Picture_I           (Start_Picture_I),
    .Done_Picture_O            (Done_Picture_O),
    .Start_Code_Upcoming_I     (Start_Code_Upcoming_I),
    .Start_Code_Value_I        (Start_Code_Value_I),
    .Start_Slice_Decode_O      (Start_Slice_Decode_O),
    .Done_Slice_Decode_I       (Done_Slice_Decode_I),
    .Slice_Value_I             (Slice_Value_I),
    .Slice_Write_En_I          (Slice_Write_En_I),
    .Buffer_Value_O            (Buffer_Value_O),
    .Buffer_Write_En_O         (Buffer_Write_En_O),
    .Buffer_Full_I             (Buffer_Full_I),
    .Slice_Vertical_Position_O (Slice_Vertical_Position_O),
    .Slice_Count_O             (Slice_Count_O),
    .Error_O                   (Error_O)
  );

  always #5 clock = ~clock;

  localparam int          TIMEOUT   = 4095;
  localparam logic [15:0] END_TAG   = 16'hFE01;
`ifdef SLICE_SCHED_ORDER_CHECK_EN
  localparam bit          ORDER_CHK = 1'b1;
`else
  localparam bit          ORDER_CHK = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int marker_writes = 0;
  int launch_pulses = 0;
  logic [31:0] last_marker = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Picture model: one flag per phase of the picture, plus its counters.
  bit         m_idle, m_wait, m_launch, m_run, m_run_first, m_mark, m_err;
  int         m_wait_cnt;
  logic [7:0] m_count, m_row;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_idle = 1; m_wait = 0; m_launch = 0; m_run = 0; m_run_first = 0; m_mark = 0;
      m_err = 0; m_wait_cnt = 0; m_count = 0; m_row = 0;
    end else if (m_idle) begin
      if (Start_Picture_I) begin
        m_idle = 0; m_wait = 1; m_wait_cnt = 0; m_count = 0; m_err = 0;
      end
    end else if (m_wait) begin
      if (Start_Code_Upcoming_I && Start_Code_Value_I >= 8'h01 && Start_Code_Value_I <= 8'hAF
          && Done_Slice_Decode_I) begin
        if (ORDER_CHK && (Start_Code_Value_I > 8'h24 || (m_count != 0 && Start_Code_Value_I < m_row)))
          m_err = 1;
        m_row = Start_Code_Value_I;
        m_wait = 0; m_launch = 1;
      end else if (Start_Code_Upcoming_I && !(Start_Code_Value_I >= 8'h01 && Start_Code_Value_I <= 8'hAF)) begin
        m_wait = 0; m_mark = 1;
      end else if (m_wait_cnt == TIMEOUT) begin
        m_err = 1; m_wait = 0; m_mark = 1;
      end else begin
        m_wait_cnt++;
      end
    end else if (m_launch) begin
      m_launch = 0; m_run = 1; m_run_first = 1;
      if (m_count != 8'hFF) m_count = m_count + 8'd1;
    end else if (m_run) begin
      if (Done_Slice_Decode_I) begin
        m_run = 0;
        if (m_run_first) begin m_err = 1; m_mark = 1; end
        else begin m_wait = 1; m_wait_cnt = 0; end
      end
      m_run_first = 0;
    end else if (m_mark) begin
      if (!Buffer_Full_I) begin m_mark = 0; m_idle = 1; end
    end
  end

  always @(negedge clock) begin
    chk("done_picture", {31'd0, Done_Picture_O}, {31'd0, m_idle});
    chk("start_slice", {31'd0, Start_Slice_Decode_O}, {31'd0, m_launch});
    chk("buf_wr_en", {31'd0, Buffer_Write_En_O}, {31'd0, (m_mark && !Buffer_Full_I) || Slice_Write_En_I});
    chk("buf_value", Buffer_Value_O, m_mark ? {END_TAG, 8'h00, m_count} : Slice_Value_I);
    chk("slice_row", {24'd0, Slice_Vertical_Position_O}, {24'd0, m_row});
    chk("slice_count", {24'd0, Slice_Count_O}, {24'd0, m_count});
    chk("error", {31'd0, Error_O}, {31'd0, m_err});
    if (m_mark && !Buffer_Full_I && Buffer_Write_En_O) begin
      marker_writes++;
      last_marker = Buffer_Value_O;
    end
    if (Start_Slice_Decode_O) launch_pulses++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_picture();
    Start_Picture_I = 1'b1;
    tick();
    Start_Picture_I = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int cycles);
    cycles = 0;
    while (!m_idle && cycles < bound) begin
      tick();
      cycles++;
    end
    if (!m_idle) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_slice(input logic [7:0] code, input int busy, input bit keep_done);
    int i;
    Start_Code_Upcoming_I = 1'b1;
    Start_Code_Value_I    = code;
    for (i = 0; i < 200; i++) begin
      tick();
      if (m_launch) break;
    end
    if (!m_launch) chk("launch_timeout", 32'd0, 32'd1);
    Start_Code_Upcoming_I = 1'b0;
    Start_Code_Value_I    = 8'h00;
    tick();
    if (keep_done) begin
      tick();
    end else begin
      Done_Slice_Decode_I = 1'b0;
      for (int b = 0; b < busy; b++) begin
        Slice_Value_I    = $urandom;
        Slice_Write_En_I = 1'($urandom_range(0, 1));
        tick();
      end
      Slice_Write_En_I    = 1'b0;
      Slice_Value_I       = '0;
      Done_Slice_Decode_I = 1'b1;
      tick();
    end
  endtask

  task automatic end_picture(input logic [7:0] code, input bit random_full);
    int i;
    int cyc;
    Start_Code_Upcoming_I = 1'b1;
    Start_Code_Value_I    = code;
    for (i = 0; i < 50 && !m_mark && !m_idle; i++) tick();
    Start_Code_Upcoming_I = 1'b0;
    Start_Code_Value_I    = 8'h00;
    for (i = 0; i < 200 && !m_idle; i++) begin
      Buffer_Full_I = random_full && ($urandom_range(0, 2) == 0);
      tick();
    end
    Buffer_Full_I = 1'b0;
    wait_idle(10, cyc);
  endtask

  initial begin
    int cyc, w0, l0, n;
    logic [7:0] code;
    logic [7:0] end_codes [6];
    end_codes[0] = 8'h00; end_codes[1] = 8'hB0; end_codes[2] = 8'hB3;
    end_codes[3] = 8'hB7; end_codes[4] = 8'hFF; end_codes[5] = 8'hC5;

    resetn = 1'b0;
    Start_Picture_I = 0; Start_Code_Upcoming_I = 0; Start_Code_Value_I = 0;
    Done_Slice_Decode_I = 1; Slice_Value_I = 0; Slice_Write_En_I = 0; Buffer_Full_I = 0;
    tick(); tick();
    chk("reset_done_picture", {31'd0, Done_Picture_O}, 32'd1);
    chk("reset_buf_wr_en", {31'd0, Buffer_Write_En_O}, 32'd0);
    chk("reset_count", {24'd0, Slice_Count_O}, 32'd0);
    resetn = 1'b1;
    tick();

    // Three slices, then a non-slice code ends the picture.
    l0 = launch_pulses;
    start_picture();
    do_slice(8'h01, 50, 0);
    do_slice(8'h02, 50, 0);
    do_slice(8'h03, 50, 0);
    end_picture(8'hB3, 0);
    chk("t1_launches", launch_pulses - l0, 32'd3);
    chk("t1_count", {24'd0, Slice_Count_O}, 32'h03);
    chk("t1_marker_low", {24'd0, last_marker[7:0]}, 32'h03);
    chk("t1_marker_tag", {16'd0, last_marker[31:16]}, 32'hFE01);
    chk("t1_done_picture", {31'd0, Done_Picture_O}, 32'd1);

    // Marker held back while the buffer is full.
    start_picture();
    do_slice(8'h10, 5, 0);
    Buffer_Full_I = 1'b1;
    Start_Code_Upcoming_I = 1'b1;
    Start_Code_Value_I = 8'hB7;
    for (int i = 0; i < 20 && !m_mark; i++) tick();
    Start_Code_Upcoming_I = 1'b0;
    w0 = marker_writes;
    repeat (20) tick();
    chk("t2_no_write_full", marker_writes - w0, 32'd0);
    chk("t2_held", {31'd0, Done_Picture_O}, 32'd0);
    Buffer_Full_I = 1'b0;
    wait_idle(10, cyc);
    chk("t2_one_marker", marker_writes - w0, 32'd1);

    // Slice ends with no start code upcoming: watchdog abort.
    start_picture();
    do_slice(8'h07, 3, 0);
    w0 = marker_writes;
    wait_idle(5000, cyc);
    chk("t3_cycles", cyc, 32'd4097);
    chk("t3_error", {31'd0, Error_O}, 32'd1);
    chk("t3_marker", marker_writes - w0, 32'd1);

    // Row order 05 then 03, with a stray Start_Picture_I mid-picture.
    l0 = launch_pulses;
    start_picture();
    do_slice(8'h05, 4, 0);
    start_picture();
    do_slice(8'h03, 4, 0);
    chk("t5_error", {31'd0, Error_O}, {31'd0, ORDER_CHK});
    chk("t5_launches", launch_pulses - l0, 32'd2);
    end_picture(8'hB3, 0);

    // Slice_Decode never leaves idle after the launch.
    start_picture();
    do_slice(8'h09, 1, 1);
    wait_idle(20, cyc);
    chk("t7_error", {31'd0, Error_O}, 32'd1);
    chk("t7_count", {24'd0, Slice_Count_O}, 32'd1);

    // Async reset while a slice is running.
    start_picture();
    Start_Code_Upcoming_I = 1'b1;
    Start_Code_Value_I = 8'h20;
    for (int i = 0; i < 20 && !m_launch; i++) tick();
    Start_Code_Upcoming_I = 1'b0;
    tick();
    Done_Slice_Decode_I = 1'b0;
    tick(); tick();
    Slice_Write_En_I = 1'b0;
    Slice_Value_I = '0;
    #2 resetn = 1'b0;
    #1;
    chk("t6_done_picture", {31'd0, Done_Picture_O}, 32'd1);
    chk("t6_row", {24'd0, Slice_Vertical_Position_O}, 32'd0);
    chk("t6_count", {24'd0, Slice_Count_O}, 32'd0);
    chk("t6_start", {31'd0, Start_Slice_Decode_O}, 32'd0);
    chk("t6_buf_value", Buffer_Value_O, 32'd0);
    tick();
    Done_Slice_Decode_I = 1'b1;
    tick();
    resetn = 1'b1;
    tick();
    start_picture();
    do_slice(8'h02, 6, 0);
    end_picture(8'h00, 0);
    chk("t6_after_count", {24'd0, Slice_Count_O}, 32'd1);
    chk("t6_after_error", {31'd0, Error_O}, 32'd0);

    // Slice count saturates at FF.
    start_picture();
    repeat (256) do_slice(8'h01, 1, 0);
    end_picture(8'h00, 0);
    chk("sat_count", {24'd0, Slice_Count_O}, 32'hFF);
    chk("sat_marker_low", {24'd0, last_marker[7:0]}, 32'hFF);

    // Random pictures, including the 0xAF / 0xB0 boundary codes.
    for (int p = 0; p < 8; p++) begin
      start_picture();
      n = $urandom_range(1, 5);
      for (int s = 0; s < n; s++) begin
        code = ($urandom_range(0, 4) == 0) ? 8'hAF : 8'($urandom_range(1, 175));
        do_slice(code, $urandom_range(1, 20), 0);
      end
      end_picture(end_codes[$urandom_range(0, 5)], 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
